ultrasonic_ranger: RTL and testbench

ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

---
 rtl/ultrasonic_pkg.sv | 19 +
 rtl/ultrasonic_ranger_sync_2ff.sv | 22 ++
 rtl/ultrasonic_ranger.sv | 167 ++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared state encoding and default timing constants for the ultrasonic ranger.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    localparam int unsigned DEF_NUM_CH         = 2;
    localparam int unsigned DEF_TRIG_CYCLES    = 500;
    localparam int unsigned DEF_CM_DIV         = 2900;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1500000;
    localparam int unsigned DEF_MEAS_PERIOD    = 3000000;
    localparam int unsigned DEF_DIST_W         = 9;

endpackage

// File: rtl/ultrasonic_ranger_sync_2ff.sv
// Two-flop synchroniser for one asynchronous echo line.
module sync_2ff (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the raw line, then re-time it once more before use.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ultrasonic_ranger.sv
// Round-robin multi-channel ultrasonic ranger sharing one measurement datapath.
module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int unsigned NUM_CH         = DEF_NUM_CH,
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned CM_DIV         = DEF_CM_DIV,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MEAS_PERIOD    = DEF_MEAS_PERIOD,
    parameter int unsigned DIST_W         = DEF_DIST_W
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        echo,
    output logic [NUM_CH-1:0]        trig,
    output logic [NUM_CH*DIST_W-1:0] distance,
    output logic [NUM_CH-1:0]        valid,
    output logic [NUM_CH-1:0]        timeout
);

    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TRIG_W = $clog2(TRIG_CYCLES + 1);
    localparam int unsigned SUB_W  = $clog2(CM_DIV + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PER_W  = $clog2(MEAS_PERIOD + 1);
    localparam logic [DIST_W-1:0] DIST_MAX = '1;

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [CH_W-1:0]     ch_next;
    logic [TRIG_W-1:0]   trig_cnt;
    logic [SUB_W-1:0]    sub_cnt;
    logic [SUB_W-1:0]    sub_step;
    logic [DIST_W-1:0]   cm_cnt;
    logic [DIST_W-1:0]   cm_step;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [PER_W-1:0]    per_cnt;
    logic [NUM_CH-1:0]   echo_s;
    logic                echo_sel;
    logic                echo_prev;
    logic                tmo_hit;

    // One synchroniser per raw echo line.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_sync
        sync_2ff u_sync (
            .clock  (clock),
            .resetn (resetn),
            .d      (echo[c]),
            .q      (echo_s[c])
        );
    end

    assign echo_sel = echo_s[ch];
    assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign ch_next  = (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);

    // One echo-high clock of the centimetre counter; cm saturates at all ones.
    always_comb begin
        sub_step = sub_cnt + SUB_W'(1);
        cm_step  = cm_cnt;
        if (sub_cnt == SUB_W'(CM_DIV - 1)) begin
            sub_step = '0;
            if (cm_cnt != DIST_MAX) begin
                cm_step = cm_cnt + DIST_W'(1);
            end
        end
    end

    // Measurement sequencer with registered trig/valid/distance/timeout.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ch        <= '0;
            trig      <= '0;
            valid     <= '0;
            timeout   <= '0;
            distance  <= '0;
            trig_cnt  <= '0;
            sub_cnt   <= '0;
            cm_cnt    <= '0;
            tmo_cnt   <= '0;
            per_cnt   <= '0;
            echo_prev <= 1'b0;
        end else begin
            valid <= '0;
            if (state != IDLE) begin
                per_cnt <= per_cnt + PER_W'(1);
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= TRIG;
                        trig     <= '0;
                        trig[ch] <= 1'b1;
                        trig_cnt <= '0;
                        per_cnt  <= '0;
                    end
                end
                TRIG: begin
                    if (trig_cnt == TRIG_W'(TRIG_CYCLES - 1)) begin
                        state     <= WAIT_RISE;
                        trig      <= '0;
                        tmo_cnt   <= '0;
                        sub_cnt   <= '0;
                        cm_cnt    <= '0;
                        echo_prev <= 1'b1;  // echo already high here is not a rise
                    end else begin
                        trig_cnt <= trig_cnt + TRIG_W'(1);
                    end
                end
                WAIT_RISE: begin
                    echo_prev <= echo_sel;
                    if (tmo_hit) begin
                        state                          <= HOLDOFF;
                        distance[ch*DIST_W +: DIST_W]  <= DIST_MAX;
                        timeout[ch]                    <= 1'b1;
                        valid[ch]                      <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (echo_sel && !echo_prev) begin
                            state   <= MEASURE;
                            sub_cnt <= sub_step;
                            cm_cnt  <= cm_step;
                        end
                    end
                end
                MEASURE: begin
                    if (tmo_hit) begin
                        state                          <= HOLDOFF;
                        distance[ch*DIST_W +: DIST_W]  <= DIST_MAX;
                        timeout[ch]                    <= 1'b1;
                        valid[ch]                      <= 1'b1;
                    end else if (!echo_sel) begin
                        state                          <= HOLDOFF;
                        distance[ch*DIST_W +: DIST_W]  <= cm_cnt;
                        timeout[ch]                    <= 1'b0;
                        valid[ch]                      <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        sub_cnt <= sub_step;
                        cm_cnt  <= cm_step;
                    end
                end
                HOLDOFF: begin
                    if (per_cnt == PER_W'(MEAS_PERIOD - 1)) begin
                        ch      <= ch_next;
                        per_cnt <= '0;
                        if (enable) begin
                            state         <= TRIG;
                            trig          <= '0;
                            trig[ch_next] <= 1'b1;
                            trig_cnt      <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    trig  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Randomised bench for ultrasonic_ranger against a per-measurement timeline model.
module tb_ultrasonic_ranger;

    localparam int NC   = 2;
    localparam int TC   = 5;
    localparam int CD   = 4;
    localparam int TO   = 200;
    localparam int MP   = 400;
    localparam int DW   = 6;
    localparam int NCYC = 12000;
    localparam int AMAX = NCYC + 4;

    logic             clock;
    logic             resetn;
    logic             enable;
    logic [NC-1:0]    echo;
    logic [NC-1:0]    trig;
    logic [NC*DW-1:0] distance;
    logic [NC-1:0]    valid;
    logic [NC-1:0]    timeout;

    logic             enable_b;
    logic [NC-1:0]    echo_b;
    logic [NC-1:0]    trig_b;
    logic [NC*DW-1:0] distance_b;
    logic [NC-1:0]    valid_b;
    logic [NC-1:0]    timeout_b;

    int n_checks;
    int n_fail;

    logic             en_a     [0:AMAX];
    logic [NC-1:0]    echo_a   [0:AMAX];
    logic [NC-1:0]    exp_trig [0:AMAX];
    logic [NC-1:0]    exp_valid[0:AMAX];
    logic [NC*DW-1:0] exp_dist [0:AMAX];
    logic [NC-1:0]    exp_tmo  [0:AMAX];
    bit               post_flag[0:AMAX];
    int               post_ch  [0:AMAX];
    int               post_d   [0:AMAX];
    bit               post_t   [0:AMAX];

    ultrasonic_ranger #(
        .NUM_CH(NC), .TRIG_CYCLES(TC), .CM_DIV(CD),
        .TIMEOUT_CYCLES(TO), .MEAS_PERIOD(MP), .DIST_W(DW)
    ) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .echo(echo),
        .trig(trig), .distance(distance), .valid(valid), .timeout(timeout)
    );

    ultrasonic_ranger #(
        .NUM_CH(NC), .TRIG_CYCLES(TC), .CM_DIV(CD),
        .TIMEOUT_CYCLES(1000), .MEAS_PERIOD(1200), .DIST_W(DW)
    ) dut_b (
        .clock(clock), .resetn(resetn), .enable(enable_b), .echo(echo_b),
        .trig(trig_b), .distance(distance_b), .valid(valid_b), .timeout(timeout_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int n, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, n, got, exp);
        end
    endtask

    // Synchronised echo seen by the sequencer at edge n (two edges of latency).
    function automatic bit es(input int c, input int n);
        if (n < 3 || n - 2 > AMAX) return 1'b0;
        return echo_a[n-2][c];
    endfunction

    initial begin : main
        int t, r, fe, p, m, fall, len, mch, dd, seg, k;
        bit to, lvl, v, got;
        logic [NC*DW-1:0] cur_d;
        logic [NC-1:0]    cur_t;

        n_checks = 0;
        n_fail   = 0;

        // Directed opening scenarios, then random echoes and random enable runs.
        for (int n = 0; n <= AMAX; n++) begin
            en_a[n]   = (n <= 8000);
            echo_a[n] = '0;
        end
        for (int n = 46;   n <= 85;   n++) echo_a[n][0] = 1'b1;
        for (int n = 20;   n <= 60;   n++) echo_a[n][1] = 1'b1;
        for (int n = 100;  n <= 120;  n++) echo_a[n][1] = 1'b1;
        for (int n = 450;  n <= 549;  n++) echo_a[n][1] = 1'b1;
        for (int n = 1250; n <= 1549; n++) echo_a[n][1] = 1'b1;
        for (int c = 0; c < NC; c++) begin
            k   = 1601;
            lvl = 1'b0;
            while (k <= AMAX) begin
                seg = lvl ? int'($urandom_range(1, 300)) : int'($urandom_range(1, 220));
                for (int i = 0; i < seg && k <= AMAX; i++) begin
                    echo_a[k][c] = lvl;
                    k++;
                end
                lvl = ~lvl;
            end
        end
        k = 8001;
        while (k <= AMAX) begin
            seg = int'($urandom_range(50, 900));
            v   = (($urandom % 4) != 0);
            for (int i = 0; i < seg && k <= AMAX; i++) begin
                en_a[k] = v;
                k++;
            end
        end

        // Model: walk measurement by measurement, deriving each post from the echo timeline.
        for (int n = 0; n <= AMAX; n++) begin
            exp_trig[n]  = '0;
            exp_valid[n] = '0;
            post_flag[n] = 1'b0;
        end
        t   = 1;
        mch = 0;
        while (t <= NCYC) begin
            if (!en_a[t]) begin
                t++;
                continue;
            end
            r  = t;
            fe = r + TC;
            for (int i = r; i < fe && i <= AMAX; i++) exp_trig[i][mch] = 1'b1;
            p  = fe + TO;
            dd = 63;
            to = 1'b1;
            for (m = fe + 2; m < fe + TO; m++) begin
                if (es(mch, m) && !es(mch, m - 1)) begin
                    fall = m + 1;
                    while (fall < fe + TO && es(mch, fall)) fall++;
                    if (fall < fe + TO) begin
                        p   = fall;
                        to  = 1'b0;
                        len = fall - m;
                        dd  = (len / CD > 63) ? 63 : len / CD;
                    end
                    break;
                end
            end
            if (p <= AMAX) begin
                exp_valid[p][mch] = 1'b1;
                post_flag[p]      = 1'b1;
                post_ch[p]        = mch;
                post_d[p]         = dd;
                post_t[p]         = to;
            end
            mch = (mch + 1) % NC;
            t   = r + MP;
        end
        cur_d = '0;
        cur_t = '0;
        for (int n = 0; n <= AMAX; n++) begin
            if (post_flag[n]) begin
                cur_d[post_ch[n]*DW +: DW] = DW'(post_d[n]);
                cur_t[post_ch[n]]          = post_t[n];
            end
            exp_dist[n] = cur_d;
            exp_tmo[n]  = cur_t;
        end

        // Reset, then release on a falling edge so edge 1 is the first active one.
        resetn   = 1'b0;
        enable   = 1'b0;
        echo     = '0;
        enable_b = 1'b0;
        echo_b   = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_trig", 0, 32'(trig), 32'(0));
        chk("reset_distance", 0, 32'(distance), 32'(0));
        @(negedge clock);
        resetn = 1'b1;

        for (int n = 1; n <= NCYC; n++) begin
            enable   = en_a[n];
            echo     = echo_a[n];
            enable_b = 1'b1;
            echo_b   = {1'b0, (n >= 46 && n <= 305)};
            @(posedge clock);
            #1;
            chk("trig", n, 32'(trig), 32'(exp_trig[n]));
            chk("valid", n, 32'(valid), 32'(exp_valid[n]));
            chk("distance", n, 32'(distance), 32'(exp_dist[n]));
            chk("timeout", n, 32'(timeout), 32'(exp_tmo[n]));
            if (n == 1)    chk("lit_trig0_rise", n, 32'(trig), 32'(2'b01));
            if (n == 5)    chk("lit_trig0_last", n, 32'(trig), 32'(2'b01));
            if (n == 6)    chk("lit_trig0_fall", n, 32'(trig), 32'(2'b00));
            if (n == 88) begin
                chk("lit_d0_10", n, 32'(distance[DW-1:0]), 32'(10));
                chk("lit_v0_pulse", n, 32'(valid), 32'(2'b01));
                chk("lit_t0_clear", n, 32'(timeout[0]), 32'(0));
            end
            if (n == 89)   chk("lit_v0_one_cycle", n, 32'(valid), 32'(0));
            if (n == 400) begin
                chk("lit_trig1_not_yet", n, 32'(trig), 32'(0));
                chk("lit_d1_ignored", n, 32'(distance[2*DW-1:DW]), 32'(0));
            end
            if (n == 401)  chk("lit_trig1_rise", n, 32'(trig), 32'(2'b10));
            if (n == 552) begin
                chk("lit_d1_25", n, 32'(distance[2*DW-1:DW]), 32'(25));
                chk("lit_v1_pulse", n, 32'(valid), 32'(2'b10));
            end
            if (n == 1005) chk("lit_v0_pre_timeout", n, 32'(valid), 32'(0));
            if (n == 1006) begin
                chk("lit_tmo0_valid", n, 32'(valid), 32'(2'b01));
                chk("lit_tmo0_dist", n, 32'(distance[DW-1:0]), 32'(63));
                chk("lit_tmo0_flag", n, 32'(timeout[0]), 32'(1));
            end
            if (n == 1406) begin
                chk("lit_tmo1_long_echo_dist", n, 32'(distance[2*DW-1:DW]), 32'(63));
                chk("lit_tmo1_long_echo_flag", n, 32'(timeout[1]), 32'(1));
                chk("lit_tmo1_long_echo_valid", n, 32'(valid), 32'(2'b10));
            end
            if (n == 307)  chk("lit_b_no_valid_yet", n, 32'(valid_b), 32'(0));
            if (n == 308) begin
                chk("lit_b_sat_valid", n, 32'(valid_b), 32'(2'b01));
                chk("lit_b_sat_dist", n, 32'(distance_b[DW-1:0]), 32'(63));
                chk("lit_b_sat_no_tmo", n, 32'(timeout_b[0]), 32'(0));
            end
            @(negedge clock);
        end

        // Asynchronous reset in the middle of a trigger pulse.
        enable = 1'b1;
        echo   = '0;
        got    = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(posedge clock);
            #1;
            if (trig != '0) got = 1'b1;
        end
        chk("reset_wait_trig", 0, 32'(got), 32'(1));
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("midtrig_reset_trig", 0, 32'(trig), 32'(0));
        chk("midtrig_reset_valid", 0, 32'(valid), 32'(0));
        chk("midtrig_reset_timeout", 0, 32'(timeout), 32'(0));
        chk("midtrig_reset_distance", 0, 32'(distance), 32'(0));
        @(negedge clock);
        resetn = 1'b1;
        enable = 1'b1;
        @(posedge clock);
        #1;
        chk("post_reset_trig_ch0", 0, 32'(trig), 32'(2'b01));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
